// File: rtl/dm_store_buffer_pkg.sv
// Shared types for the DM store buffer: entry layout, lane count, pointer sizing.
package sb_pkg;
  localparam int LANES     = 4;
  localparam int SB_ADDR_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-3:0] addr_w;
    logic [LANES-1:0]     be;
    logic [31:0]          data;
    logic [31:0]          pc;
  } sb_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/sb_fwd_merge.sv
// Per-lane load forwarding: youngest valid entry whose word address matches and
// whose lane enable is set supplies that byte.
module sb_fwd_merge
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] ents,
  input  logic [DEPTH-1:0]      vld,
  input  logic [PW-1:0]         head,
  input  logic [SB_ADDR_W-3:0]  ld_addr_w,
  output logic [LANES-1:0]      ld_be,
  output logic [31:0]           ld_data
);
  // Walk oldest to youngest starting at head; later matches overwrite earlier ones.
  always_comb begin
    ld_be   = '0;
    ld_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      automatic logic [PW-1:0] idx = head + PW'(k);
      if (vld[idx] && ents[idx].addr_w == ld_addr_w) begin
        for (int l = 0; l < LANES; l++) begin
          if (ents[idx].be[l]) begin
            ld_be[l]          = 1'b1;
            ld_data[8*l +: 8] = ents[idx].data[8*l +: 8];
          end
        end
      end
    end
  end
endmodule

// File: rtl/dm_store_buffer.sv
// Posted-write store FIFO in front of DM with byte-granular load forwarding.
// Define DM_STORE_TRACE_EN to print a trace line for every write drained to DM.
module dm_store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [3:0]                 st_be,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [31:0]                st_pc,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic [3:0]                 ld_be,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       dm_we,
  output logic [ADDR_W-1:0]          dm_addr,
  output logic [3:0]                 dm_be,
  output logic [DATA_W-1:0]          dm_wd,
  output logic [31:0]                dm_pc,
  input  logic                       dm_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  sb_entry_t [DEPTH-1:0] ents;
  sb_entry_t             push_ent, head_ent;
  logic [DEPTH-1:0]      vld;
  logic [PW-1:0]         head, tail;
  logic                  push, pop;
  logic                  unused;

  assign unused = ^{st_addr[1:0], ld_addr[1:0]};

  // Ready decodes only the registered count, so a full buffer stalls even while draining.
  assign st_ready = (count != CW'(DEPTH));
  assign empty    = (count == '0);
  assign dm_we    = !empty;
  // Empty-mask stores complete the handshake but never occupy a slot.
  assign push     = st_valid && st_ready && (st_be != 4'b0000);
  assign pop      = dm_we && dm_ready;

  always_comb begin
    push_ent        = '0;
    push_ent.addr_w = (SB_ADDR_W-2)'(st_addr[ADDR_W-1:2]);
    push_ent.be     = st_be;
    push_ent.data   = st_data[31:0];
    push_ent.pc     = st_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ents  <= '0;
      vld   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ents[tail] <= push_ent;
        vld[tail]  <= 1'b1;
        tail       <= tail + 1'b1;
      end
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_ent = ents[head];
  assign dm_addr  = {head_ent.addr_w[ADDR_W-3:0], 2'b00};
  assign dm_be    = head_ent.be;
  assign dm_wd    = head_ent.data;
  assign dm_pc    = head_ent.pc;

  sb_fwd_merge #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
    .ents      (ents),
    .vld       (vld),
    .head      (head),
    .ld_addr_w ((SB_ADDR_W-2)'(ld_addr[ADDR_W-1:2])),
    .ld_be     (ld_be),
    .ld_data   (ld_data)
  );

  assign ld_hit = |ld_be;

`ifdef DM_STORE_TRACE_EN
  logic [31:0] merged;
  assign merged = dm_wd & {{8{dm_be[3]}}, {8{dm_be[2]}}, {8{dm_be[1]}}, {8{dm_be[0]}}};
  always @(posedge clk) begin
    if (reset && pop)
      $display("%d@%h: *%h <= %h", $time, dm_pc, dm_addr, merged);
  end
`endif
endmodule

// File: tb/tb_dm_store_buffer.sv
// Scoreboard bench for dm_store_buffer: expected DM writes queued at issue, checked by a monitor.
module tb_dm_store_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data, st_pc, ld_addr, ld_data;
  logic [3:0]  st_be, ld_be, dm_be;
  logic        ld_hit, dm_we, dm_ready, empty;
  logic [31:0] dm_addr, dm_wd, dm_pc;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   compared = 0;
  int   mism     = 0;

  dm_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_be(st_be),
    .st_data(st_data), .st_pc(st_pc),
    .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_be(ld_be), .ld_data(ld_data),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wd(dm_wd), .dm_pc(dm_pc),
    .dm_ready(dm_ready), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // A write is taken at the next rising edge whenever dm_we && dm_ready holds mid-cycle.
  always @(negedge clk) begin
    if (reset && dm_we && dm_ready) begin
      compared++;
      if (q.size() == 0) begin
        mism++;
        $display("FAIL dm_unexpected: got write addr=%h wd=%h, required no write", dm_addr, dm_wd);
      end else begin
        mon_e = q.pop_front();
        if (dm_addr !== mon_e.addr || dm_be !== mon_e.be || dm_wd !== mon_e.wd || dm_pc !== mon_e.pc) begin
          mism++;
          $display("FAIL dm_write: got addr=%h be=%h wd=%h pc=%h required addr=%h be=%h wd=%h pc=%h",
                   dm_addr, dm_be, dm_wd, dm_pc, mon_e.addr, mon_e.be, mon_e.wd, mon_e.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mism++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the store.
  task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                      input logic [31:0] pc);
    int w = 0;
    st_valid = 1'b1; st_addr = a; st_be = be; st_data = d; st_pc = pc;
    while (!st_ready && w < 20) begin
      tick(1);
      w++;
    end
    if (!st_ready) chk("push_timeout", 32'(st_ready), 32'h1);
    if (be != 4'b0000) q.push_back('{addr: {a[31:2], 2'b00}, be: be, wd: d, pc: pc});
    tick(1);
    st_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_be = '0; st_data = '0; st_pc = '0;
    ld_addr = '0; dm_ready = 1'b0;
    #2;
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_st_ready", 32'(st_ready), 32'h1);
    chk("rst_dm_we", 32'(dm_we), 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_ld_hit", 32'(ld_hit), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    tick(1);
    reset = 1'b1;
    tick(1);

    // single store, one-cycle latency to DM
    dm_ready = 1'b1;
    push(32'h0000_1000, 4'hF, 32'h1122_3344, 32'h100);
    chk("t1_dm_we", 32'(dm_we), 32'h1);
    chk("t1_dm_addr", dm_addr, 32'h0000_1000);
    chk("t1_dm_wd", dm_wd, 32'h1122_3344);
    tick(1);
    chk("t1_empty", 32'(empty), 32'h1);

    // fill while DM stalled, refuse fifth, drain in order
    dm_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(32'h5000 + 32'(4*i), 4'hF, 32'hA000_0000 + 32'(i), 32'h300 + 32'(4*i));
    chk("t2_count_full", 32'(count), 32'h4);
    chk("t2_st_ready_full", 32'(st_ready), 32'h0);
    st_valid = 1'b1; st_addr = 32'h5FF0; st_be = 4'hF; st_data = 32'hDEAD_DEAD; st_pc = 32'h3FC;
    tick(1);
    chk("t2_fifth_refused", 32'(count), 32'h4);
    st_valid = 1'b0;
    dm_ready = 1'b1;
    tick(1);
    chk("t2_ready_after_pop", 32'(st_ready), 32'h1);
    chk("t2_count_after_pop", 32'(count), 32'h3);
    tick(3);
    chk("t2_drained", 32'(empty), 32'h1);

    // youngest-wins byte forwarding
    dm_ready = 1'b0;
    push(32'h2001, 4'b0010, 32'h0000_AA00, 32'h400);
    push(32'h2001, 4'b0010, 32'h0000_BB00, 32'h404);
    ld_addr = 32'h2000; #1;
    chk("t3_ld_hit", 32'(ld_hit), 32'h1);
    chk("t3_ld_be", 32'(ld_be), 32'h2);
    chk("t3_ld_data", ld_data, 32'h0000_BB00);

    push(32'h3000, 4'b0011, 32'h0000_BEEF, 32'h408);
    ld_addr = 32'h3004; #1;
    chk("t4_miss", 32'(ld_hit), 32'h0);
    ld_addr = 32'h3002; #1;
    chk("t4_ld_be", 32'(ld_be), 32'h3);
    chk("t4_ld_data", ld_data, 32'h0000_BEEF);

    // zero-mask store: accepted, not enqueued
    push(32'h7000, 4'b0000, 32'h1234_5678, 32'h40C);
    chk("t4_zero_be_count", 32'(count), 32'h3);

    // simultaneous push and pop at count 3
    dm_ready = 1'b1;
    push(32'h4000, 4'hF, 32'hCAFE_F00D, 32'h410);
    chk("t5_count", 32'(count), 32'h3);
    chk("t5_next_head", dm_wd, 32'h0000_BB00);
    tick(3);
    chk("t5_drained", 32'(empty), 32'h1);

    // pointer wrap over 10 back-to-back push/pop cycles
    for (int i = 0; i < 10; i++)
      push(32'h6000 + 32'(4*i), 4'(i % 15 + 1), 32'h0101_0101 * 32'(i + 1), 32'h500 + 32'(4*i));
    tick(2);
    chk("t6_empty", 32'(empty), 32'h1);

    // reset pulse mid-drain discards pending entries
    dm_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(32'h8000 + 32'(4*i), 4'hF, 32'h8800_0000 + 32'(i), 32'h600 + 32'(4*i));
    chk("t7_count3", 32'(count), 32'h3);
    dm_ready = 1'b1;
    tick(1);
    reset = 1'b0;
    q.delete();
    #1;
    chk("t7_rst_dm_we", 32'(dm_we), 32'h0);
    chk("t7_rst_count", 32'(count), 32'h0);
    #4;
    reset = 1'b1;
    tick(5);
    chk("t7_empty_after", 32'(empty), 32'h1);
    chk("sb_leftover", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
